// File: rtl/async_fifo_pkg.sv
// Shared types and default configuration for the FIFO write-side arbiter.
package async_fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH     = 32;
    localparam int unsigned DEFAULT_NUM_REQ        = 4;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;

    // IDLE arbitrates; LOCK owns the FIFO write port until a packet's last beat.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/async_fifo_rr_pick.sv
// Round-robin pick: first set bit of valid at or after rr_ptr, wrapping modulo NUM_REQ.
module async_fifo_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               found,
    output logic [IDX_W-1:0]   index
);

    // Scan upward from rr_ptr; the first hit wins.
    always_comb begin
        int unsigned cand;
        cand  = 0;
        found = 1'b0;
        index = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (32'(rr_ptr) + k) % NUM_REQ;
            if (!found && valid[IDX_W'(cand)]) begin
                found = 1'b1;
                index = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/async_fifo_wr_arb.sv
// Packet-atomic round-robin arbiter feeding the write side of an async FIFO.
// Optional stall watchdog enabled by defining ASYNC_FIFO_ARB_TIMEOUT_EN.
module async_fifo_wr_arb
    import async_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int unsigned NUM_REQ        = DEFAULT_NUM_REQ,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                          wr_clk,
    input  logic                          wr_rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_wr_full,
    output logic                          arb_busy,
    output logic [$clog2(NUM_REQ)-1:0]    arb_grant_id,
    output logic                          arb_timeout_err
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arb_state_t       state;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] next_ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             grant_valid;
    logic             accept;
    logic             tmo_hit;

    async_fifo_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .valid  (req_valid),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .index  (pick_idx)
    );

    // Beat handshake for the granted requester and the pointer value after it.
    always_comb begin
        grant_valid = req_valid[grant];
        accept      = (state == LOCK) && grant_valid && !fifo_wr_full;
        next_ptr    = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);
    end

`ifdef ASYNC_FIFO_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_err;

    // Fires on the cycle that would bring the idle-valid count up to the limit.
    assign tmo_hit = (state == LOCK) && !grant_valid &&
                     (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count LOCK cycles with the owner's valid low; a full-stalled valid beat holds.
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            tmo_cnt <= '0;
            tmo_err <= 1'b0;
        end else begin
            if (state != LOCK || accept || tmo_hit) begin
                tmo_cnt <= '0;
            end else if (!grant_valid) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
            if (tmo_hit) begin
                tmo_err <= 1'b1;
            end
        end
    end

    assign arb_timeout_err = tmo_err;
`else
    assign tmo_hit         = 1'b0;
    assign arb_timeout_err = 1'b0;
`endif

    // Arbitration FSM: grant in IDLE, release after the last beat (or a watchdog hit).
    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant <= pick_idx;
                        state <= LOCK;
                    end
                end
                LOCK: begin
                    if ((accept && req_last[grant]) || tmo_hit) begin
                        state  <= IDLE;
                        rr_ptr <= next_ptr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write-port outputs follow the live inputs so beats pass with no added latency.
    always_comb begin
        req_ready = '0;
        if (state == LOCK) begin
            req_ready[grant] = !fifo_wr_full;
        end
        fifo_wr_en   = accept;
        fifo_wr_data = req_data[grant*DATA_WIDTH +: DATA_WIDTH];
        arb_busy     = (state == LOCK);
        arb_grant_id = grant;
    end

endmodule

// File: tb/tb_async_fifo_wr_arb.sv
// Directed bench for async_fifo_wr_arb: a vector table plus multi-cycle sequences.
module tb_async_fifo_wr_arb;

    localparam int unsigned DW = 8;
    localparam int unsigned NR = 4;

    logic             wr_clk;
    logic             wr_rst_n;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_last;
    logic [NR-1:0]    req_ready;
    logic             fifo_wr_en;
    logic [DW-1:0]    fifo_wr_data;
    logic             fifo_wr_full;
    logic             arb_busy;
    logic [1:0]       arb_grant_id;
    logic             arb_timeout_err;

    int checks;
    int failures;

    logic [DW-1:0] wlog[$];

    async_fifo_wr_arb #(
        .DATA_WIDTH     (DW),
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .wr_clk          (wr_clk),
        .wr_rst_n        (wr_rst_n),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_last        (req_last),
        .req_ready       (req_ready),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_wr_data    (fifo_wr_data),
        .fifo_wr_full    (fifo_wr_full),
        .arb_busy        (arb_busy),
        .arb_grant_id    (arb_grant_id),
        .arb_timeout_err (arb_timeout_err)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    // Record every beat the FIFO would take.
    always @(posedge wr_clk) begin
        if (wr_rst_n && fifo_wr_en) wlog.push_back(fifo_wr_data);
    end

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic        full;
        logic [31:0] data;
        logic [3:0]  e_ready;
        logic        e_en;
        logic [7:0]  e_data;
        logic        e_busy;
        logic [1:0]  e_gid;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Leaves reset released right at a falling edge with all inputs idle.
    task automatic do_reset();
        @(negedge wr_clk);
        wr_rst_n     = 1'b0;
        req_valid    = '0;
        req_last     = '0;
        req_data     = '0;
        fifo_wr_full = 1'b0;
        @(negedge wr_clk);
        @(negedge wr_clk);
        wr_rst_n = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " ready"}, 32'(req_ready), 32'h0);
        chk({tag, " wr_en"}, 32'(fifo_wr_en), 32'h0);
        chk({tag, " busy"}, 32'(arb_busy), 32'h0);
        chk({tag, " gid"}, 32'(arb_grant_id), 32'h0);
        chk({tag, " err"}, 32'(arb_timeout_err), 32'h0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        wr_rst_n     = 1'b0;
        req_valid    = '0;
        req_last     = '0;
        req_data     = '0;
        fifo_wr_full = 1'b0;

        //          valid    last     full  data           rdy      en    dat    busy  gid
        vecs[0]  = '{4'b0010, 4'b0000, 1'b0, 32'h0000A000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
        vecs[1]  = '{4'b0010, 4'b0000, 1'b0, 32'h0000A000, 4'b0010, 1'b1, 8'hA0, 1'b1, 2'd1};
        vecs[2]  = '{4'b0010, 4'b0000, 1'b0, 32'h0000A100, 4'b0010, 1'b1, 8'hA1, 1'b1, 2'd1};
        vecs[3]  = '{4'b0010, 4'b0010, 1'b0, 32'h0000A200, 4'b0010, 1'b1, 8'hA2, 1'b1, 2'd1};
        vecs[4]  = '{4'b0000, 4'b0000, 1'b0, 32'h00000000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd1};
        vecs[5]  = '{4'b0011, 4'b0000, 1'b0, 32'h0000C0B0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd1};
        vecs[6]  = '{4'b0011, 4'b0000, 1'b0, 32'h0000C0B0, 4'b0001, 1'b1, 8'hB0, 1'b1, 2'd0};
        vecs[7]  = '{4'b0011, 4'b0001, 1'b0, 32'h0000C0B1, 4'b0001, 1'b1, 8'hB1, 1'b1, 2'd0};
        vecs[8]  = '{4'b0010, 4'b0010, 1'b0, 32'h0000C000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
        vecs[9]  = '{4'b0010, 4'b0010, 1'b0, 32'h0000C000, 4'b0010, 1'b1, 8'hC0, 1'b1, 2'd1};
        vecs[10] = '{4'b0000, 4'b0000, 1'b0, 32'h00000000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd1};
        vecs[11] = '{4'b0100, 4'b0000, 1'b0, 32'h00D00000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd1};
        vecs[12] = '{4'b0100, 4'b0000, 1'b0, 32'h00D00000, 4'b0100, 1'b1, 8'hD0, 1'b1, 2'd2};
        vecs[13] = '{4'b0100, 4'b0000, 1'b1, 32'h00D10000, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd2};
        vecs[14] = '{4'b0000, 4'b0000, 1'b0, 32'h00D10000, 4'b0100, 1'b0, 8'h00, 1'b1, 2'd2};
        vecs[15] = '{4'b0101, 4'b0100, 1'b0, 32'h00D100E0, 4'b0100, 1'b1, 8'hD1, 1'b1, 2'd2};
        vecs[16] = '{4'b0001, 4'b0001, 1'b0, 32'h000000E0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd2};
        vecs[17] = '{4'b0001, 4'b0001, 1'b0, 32'h000000E0, 4'b0001, 1'b1, 8'hE0, 1'b1, 2'd0};
        vecs[18] = '{4'b0000, 4'b0000, 1'b0, 32'h00000000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};

        // Reset values, including mid-reset.
        @(negedge wr_clk);
        #1 chk_zero("reset");
        do_reset();
        #1 chk_zero("post_reset");

        // Vector table: one entry per clock.
        for (int i = 0; i < 19; i++) begin
            req_valid    = vecs[i].valid;
            req_last     = vecs[i].last;
            fifo_wr_full = vecs[i].full;
            req_data     = vecs[i].data;
            #1;
            chk($sformatf("v%0d ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
            chk($sformatf("v%0d wr_en", i), 32'(fifo_wr_en), 32'(vecs[i].e_en));
            if (vecs[i].e_en)
                chk($sformatf("v%0d data", i), 32'(fifo_wr_data), 32'(vecs[i].e_data));
            chk($sformatf("v%0d busy", i), 32'(arb_busy), 32'(vecs[i].e_busy));
            chk($sformatf("v%0d gid", i), 32'(arb_grant_id), 32'(vecs[i].e_gid));
            chk($sformatf("v%0d err", i), 32'(arb_timeout_err), 32'h0);
            @(negedge wr_clk);
        end

        // Round robin from reset with every requester sending 1-beat packets.
        do_reset();
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        req_data  = 32'h33221100;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk($sformatf("rr%0d busy", c), 32'(arb_busy), 32'(c % 2));
            chk($sformatf("rr%0d wr_en", c), 32'(fifo_wr_en), 32'(c % 2));
            if (c % 2 == 1) begin
                chk($sformatf("rr%0d gid", c), 32'(arb_grant_id), 32'((c / 2) % 4));
                chk($sformatf("rr%0d ready", c), 32'(req_ready), 32'(1 << ((c / 2) % 4)));
            end
            @(negedge wr_clk);
        end

        // Full stall in the middle of a 3-beat packet from req 2.
        do_reset();
        wlog.delete();
        req_valid = 4'b0100;
        req_data  = 32'h00F00000;
        #1 chk("st idle busy", 32'(arb_busy), 32'h0);
        @(negedge wr_clk);
        #1;
        chk("st beat0 en", 32'(fifo_wr_en), 32'h1);
        chk("st beat0 data", 32'(fifo_wr_data), 32'hF0);
        @(negedge wr_clk);
        req_data     = 32'h00F10000;
        fifo_wr_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("st full%0d en", k), 32'(fifo_wr_en), 32'h0);
            chk($sformatf("st full%0d ready", k), 32'(req_ready), 32'h0);
            chk($sformatf("st full%0d gid", k), 32'(arb_grant_id), 32'h2);
            @(negedge wr_clk);
        end
        fifo_wr_full = 1'b0;
        #1;
        chk("st beat1 en", 32'(fifo_wr_en), 32'h1);
        chk("st beat1 data", 32'(fifo_wr_data), 32'hF1);
        @(negedge wr_clk);
        req_data = 32'h00F20000;
        req_last = 4'b0100;
        #1 chk("st beat2 en", 32'(fifo_wr_en), 32'h1);
        @(negedge wr_clk);
        req_valid = '0;
        req_last  = '0;
        #1;
        chk("st end busy", 32'(arb_busy), 32'h0);
        chk("st beats", 32'(wlog.size()), 32'd3);
        if (wlog.size() == 3) begin
            chk("st log0", 32'(wlog[0]), 32'hF0);
            chk("st log1", 32'(wlog[1]), 32'hF1);
            chk("st log2", 32'(wlog[2]), 32'hF2);
        end

        // Asynchronous reset mid-packet.
        do_reset();
        req_valid = 4'b1000;
        req_data  = 32'h30000000;
        @(negedge wr_clk);
        #1 chk("ar lock en", 32'(fifo_wr_en), 32'h1);
        #2;
        wr_rst_n  = 1'b0;
        req_valid = 4'b1010;
        #1 chk_zero("ar async");
        @(negedge wr_clk);
        #2 wr_rst_n = 1'b1;
        @(negedge wr_clk);
        #1;
        chk("ar regrant busy", 32'(arb_busy), 32'h1);
        chk("ar regrant gid", 32'(arb_grant_id), 32'h1);

        // Requester 3 goes quiet for 8 cycles after one beat.
        do_reset();
        req_valid = 4'b1000;
        req_data  = 32'h60000000;
        #1 chk("to idle busy", 32'(arb_busy), 32'h0);
        @(negedge wr_clk);
        #1;
        chk("to beat en", 32'(fifo_wr_en), 32'h1);
        chk("to beat gid", 32'(arb_grant_id), 32'h3);
        @(negedge wr_clk);
        req_valid = 4'b0110;
        for (int k = 1; k <= 8; k++) begin
            #1;
            chk($sformatf("to drop%0d busy", k), 32'(arb_busy), 32'h1);
            chk($sformatf("to drop%0d err", k), 32'(arb_timeout_err), 32'h0);
            @(negedge wr_clk);
        end
        #1;
`ifdef ASYNC_FIFO_ARB_TIMEOUT_EN
        chk("to rel busy", 32'(arb_busy), 32'h0);
        chk("to rel err", 32'(arb_timeout_err), 32'h1);
        @(negedge wr_clk);
        #1;
        chk("to next gid", 32'(arb_grant_id), 32'h1);
        chk("to next busy", 32'(arb_busy), 32'h1);
        repeat (3) @(negedge wr_clk);
        #1 chk("to sticky err", 32'(arb_timeout_err), 32'h1);
`else
        chk("to hold busy", 32'(arb_busy), 32'h1);
        chk("to hold err", 32'(arb_timeout_err), 32'h0);
        @(negedge wr_clk);
        #1;
        chk("to hold gid", 32'(arb_grant_id), 32'h3);
        chk("to hold ready", 32'(req_ready), 32'h8);
        chk("to hold err2", 32'(arb_timeout_err), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
